// File: rtl/shift_rotate_n.sv
// WIDTH-generic shift/rotate/Johnson/arithmetic register. A Start request latches
// Mode and Amt, then applies Amt single-bit steps, one per clock, and pulses done.
module shift_rotate_n #(
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [AW-1:0]    Amt,
    input  logic             Sin,
    output logic [WIDTH-1:0] q,
    output logic             Sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        M_SHL = 3'b000,
        M_SHR = 3'b001,
        M_ROL = 3'b010,
        M_ROR = 3'b011,
        M_JOL = 3'b100,
        M_JOR = 3'b101,
        M_ASR = 3'b110,
        M_RSV = 3'b111
    } mode_t;

    state_t           state, state_nx;
    mode_t            mode_r, mode_nx;
    logic [AW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] q_nx, step_q;
    logic             sout_nx, step_sout;
    logic             busy_nx, done_nx;

    // One single-bit step of the latched mode; the reserved mode holds q and Sout.
    always_comb begin
        step_q    = q;
        step_sout = Sout;
        case (mode_r)
            M_SHL: begin step_q = {q[WIDTH-2:0], Sin};       step_sout = q[WIDTH-1]; end
            M_SHR: begin step_q = {Sin, q[WIDTH-1:1]};       step_sout = q[0];       end
            M_ROL: begin step_q = {q[WIDTH-2:0], q[WIDTH-1]}; step_sout = q[WIDTH-1]; end
            M_ROR: begin step_q = {q[0], q[WIDTH-1:1]};      step_sout = q[0];       end
            M_JOL: begin step_q = {q[WIDTH-2:0], ~q[WIDTH-1]}; step_sout = q[WIDTH-1]; end
            M_JOR: begin step_q = {~q[0], q[WIDTH-1:1]};     step_sout = q[0];       end
            M_ASR: begin step_q = {q[WIDTH-1], q[WIDTH-1:1]}; step_sout = q[0];      end
            M_RSV: begin step_q = q;                         step_sout = Sout;       end
            default: begin step_q = q;                       step_sout = Sout;       end
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        mode_nx  = mode_r;
        cnt_nx   = cnt;
        q_nx     = q;
        sout_nx  = Sout;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (Load) begin
                    q_nx = D;
                end else if (Start) begin
                    mode_nx = mode_t'(Mode);
                    if (Amt != '0) begin
                        cnt_nx   = Amt;
                        state_nx = RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                q_nx    = step_q;
                sout_nx = step_sout;
                cnt_nx  = cnt - 1'b1;
                if (cnt == AW'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == RUN);
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= IDLE;
            mode_r <= M_SHL;
            cnt    <= '0;
            q      <= '0;
            Sout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_r <= mode_nx;
            cnt    <= cnt_nx;
            q      <= q_nx;
            Sout   <= sout_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_shift_rotate_n.sv
// Scoreboard bench: a 4-bit and an 8-bit instance run the same request stream in lockstep
// and every cycle of each sequence is checked against an arithmetic reference model.
module tb_shift_rotate_n;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       load = 1'b0;
    logic [7:0] d = '0;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [2:0] amt = '0;
    logic       sin = 1'b0;

    logic [3:0] q4;
    logic [7:0] q8;
    logic       sout4, sout8, busy4, busy8, done4, done8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        int   q4;
        int   q8;
        int   s4;
        int   s8;
        bit   busy;
        bit   done;
    } entry_t;

    entry_t sb[$];

    // reference-model state, always describing the register after all queued work
    int m_q4 = 0, m_q8 = 0, m_s4 = 0, m_s8 = 0;

    shift_rotate_n #(.WIDTH(4)) u4 (
        .CLK(clk), .CLR(clr), .Load(load), .D(d[3:0]), .Start(start), .Mode(mode),
        .Amt(amt), .Sin(sin), .q(q4), .Sout(sout4), .busy(busy4), .done(done4)
    );

    shift_rotate_n #(.WIDTH(8)) u8 (
        .CLK(clk), .CLR(clr), .Load(load), .D(d), .Start(start), .Mode(mode),
        .Amt({1'b0, amt}), .Sin(sin), .q(q8), .Sout(sout8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference step in plain arithmetic on a w-bit value.
    function automatic int ref_q(int w, int m, int s, int v);
        int mask = (1 << w) - 1;
        int msb  = (v >> (w - 1)) & 1;
        int lsb  = v & 1;
        case (m)
            0: return ((v << 1) | s) & mask;
            1: return (v >> 1) | (s << (w - 1));
            2: return ((v << 1) | msb) & mask;
            3: return (v >> 1) | (lsb << (w - 1));
            4: return ((v << 1) | (1 - msb)) & mask;
            5: return (v >> 1) | ((1 - lsb) << (w - 1));
            6: return (v >> 1) | (msb << (w - 1));
            default: return v;
        endcase
    endfunction

    function automatic int ref_so(int w, int m, int v, int old);
        if (m == 7) return old;
        if (m == 0 || m == 2 || m == 4) return (v >> (w - 1)) & 1;
        return v & 1;
    endfunction

    // Monitor: compare every scheduled cycle; outside them done must stay low.
    always @(negedge clk) begin
        if (clr === 1'b1) begin
            check("done_busy_exclusive4", done4 & busy4, 0);
            check("done_busy_exclusive8", done8 & busy8, 0);
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("sb_missed_slot", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                entry_t e;
                e = sb.pop_front();
                check("q4", q4, e.q4);
                check("q8", q8, e.q8);
                check("sout4", sout4, e.s4);
                check("sout8", sout8, e.s8);
                check("busy4", busy4, e.busy);
                check("busy8", busy8, e.busy);
                check("done4", done4, e.done);
                check("done8", done8, e.done);
            end else begin
                check("idle_done4", done4, 0);
                check("idle_done8", done8, 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sin = 1'($urandom);
            next_cycle();
        end
    endtask

    // Parallel load, optionally with Start raised in the same cycle (Load must win).
    task automatic do_load(input logic [7:0] val, input bit with_start);
        entry_t e;
        load  = 1'b1;
        d     = val;
        start = with_start;
        mode  = 3'($urandom);
        amt   = 3'($urandom_range(1, 7));
        m_q4  = val & 8'h0F;
        m_q8  = val;
        e = '{cyc: cyc + 1, q4: m_q4, q8: m_q8, s4: m_s4, s8: m_s8, busy: 1'b0, done: 1'b0};
        sb.push_back(e);
        next_cycle();
        load  = 1'b0;
        start = 1'b0;
    endtask

    // One Start request; returns at the cycle where done is visible, so a following
    // call issues its Start on the done edge (back-to-back).
    task automatic run_seq(input int m, input int n, input logic [7:0] sins, input bit disturb);
        int e0 = cyc + 1;
        entry_t e;
        start = 1'b1;
        load  = 1'b0;
        mode  = 3'(m);
        amt   = 3'(n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                m_s4 = ref_so(4, m, m_q4, m_s4);
                m_q4 = ref_q(4, m, int'(sins[k-1]), m_q4);
                m_s8 = ref_so(8, m, m_q8, m_s8);
                m_q8 = ref_q(8, m, int'(sins[k-1]), m_q8);
            end
            e = '{cyc: e0 + k, q4: m_q4, q8: m_q8, s4: m_s4, s8: m_s8,
                  busy: (k < n), done: (k == n)};
            sb.push_back(e);
        end
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            sin  = sins[k];
            mode = 3'($urandom);
            amt  = 3'($urandom);
            if (disturb) begin
                load  = 1'($urandom);
                start = 1'($urandom);
                d     = 8'($urandom);
            end
            next_cycle();
        end
        load  = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #1 clr = 1'b0;
        #2;
        check("rst_q4", q4, 0);
        check("rst_q8", q8, 0);
        check("rst_sout4", sout4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        idle(2);

        // rotate left one step
        do_load(8'hAB, 1'b0);
        run_seq(2, 1, 8'h00, 1'b0);
        idle(1);

        // Johnson from zero, repeated, then a long wrapping run
        do_load(8'h00, 1'b0);
        run_seq(4, 4, 8'h00, 1'b0);
        run_seq(4, 4, 8'h00, 1'b0);
        run_seq(4, 7, 8'h00, 1'b0);
        idle(1);

        // serial shift left and right with stream 1,0,1,1
        do_load(8'h00, 1'b0);
        run_seq(0, 4, 8'b0000_1101, 1'b0);
        do_load(8'h00, 1'b0);
        run_seq(1, 4, 8'b0000_1101, 1'b0);

        // arithmetic right
        do_load(8'h90, 1'b0);
        run_seq(6, 3, 8'h00, 1'b0);
        do_load(8'h41, 1'b0);
        run_seq(6, 1, 8'h00, 1'b0);

        // handshake corners: Load+Start, disturbed run, Amt=0, reserved mode
        do_load(8'h5C, 1'b1);
        run_seq(3, 6, 8'h00, 1'b1);
        run_seq(2, 0, 8'h00, 1'b0);
        idle(2);
        run_seq(7, 3, 8'hFF, 1'b1);

        // abort a running sequence with CLR between edges
        do_load(8'hAB, 1'b0);
        start = 1'b1;
        mode  = 3'd2;
        amt   = 3'd6;
        next_cycle();
        start = 1'b0;
        next_cycle();
        #2;
        check("pre_abort_busy4", busy4, 1);
        clr = 1'b0;
        #1;
        check("abort_q4", q4, 0);
        check("abort_q8", q8, 0);
        check("abort_busy4", busy4, 0);
        check("abort_busy8", busy8, 0);
        check("abort_sout4", sout4, 0);
        check("abort_done4", done4, 0);
        sb.delete();
        m_q4 = 0; m_q8 = 0; m_s4 = 0; m_s8 = 0;
        @(posedge clk);
        #1 clr = 1'b1;
        idle(4);

        // randomized mix of loads, sequences and idle gaps
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 2)
                do_load(8'($urandom), 1'($urandom));
            else if (r < 9)
                run_seq($urandom_range(0, 7), $urandom_range(0, 7), 8'($urandom), 1'($urandom));
            else
                idle($urandom_range(1, 3));
        end

        idle(3);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
